// File: rtl/usb_tx_serializer.sv
// Purpose: prepends SYNC, shifts packet bytes out LSB-first with USB bit stuffing, closes with EOP.
// Latency: first SYNC bit on the strobe that sees txValid in IDLE; first byte taken on the 9th strobe.
// Backpressure: txReady only on DATA strobes needing a byte with no stuff bit due; other bytes are held.
module usb_tx_serializer #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LIMIT  = 6,
  parameter int         EOP_BITS     = 3
) (
  input  logic       useClk,
  input  logic       reset,
  input  logic       checkData,
  input  logic       txValid,
  input  logic [7:0] txData,
  input  logic       txLast,
  output logic       txReady,
  output logic       bitOut,
  output logic       OE,
  output logic       callEop,
  output logic       underrun
);

  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int EOP_W  = $clog2(EOP_BITS + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);
  localparam logic [EOP_W-1:0]  EOP_MAX  = EOP_W'(EOP_BITS);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} stateT;

  stateT             state;
  logic [ONES_W-1:0] onesCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic              isLast;
  logic              needByte;
  logic              lastPending;   // last byte fully sent, only a stuff bit remains before EOP
  logic [EOP_W-1:0]  eopCnt;

  logic              stuffDue;
  logic              curBit;
  logic [ONES_W-1:0] onesNext;

  // Run-length of emitted ones after emitting bit b.
  function automatic logic [ONES_W-1:0] bumpOnes(input logic [ONES_W-1:0] cnt, input logic b);
    return b ? cnt + ONES_W'(1) : '0;
  endfunction

  assign stuffDue = (onesCnt == ONES_MAX);
  assign curBit   = shiftReg[bitIdx];
  assign onesNext = bumpOnes(onesCnt, curBit);
  assign txReady  = checkData & txValid & needByte & ~stuffDue & (state == DATA);

  // Packet sequencer: SYNC, stuffed data bits, EOP; advances only on bit-time strobes.
  always_ff @(posedge useClk) begin
    underrun <= 1'b0;
    if (reset) begin
      state       <= IDLE;
      bitOut      <= 1'b0;
      OE          <= 1'b0;
      callEop     <= 1'b0;
      underrun    <= 1'b0;
      onesCnt     <= '0;
      bitIdx      <= '0;
      shiftReg    <= '0;
      isLast      <= 1'b0;
      needByte    <= 1'b0;
      lastPending <= 1'b0;
      eopCnt      <= '0;
    end else if (checkData) begin
      case (state)
        IDLE: begin
          callEop <= 1'b0;
          if (txValid) begin
            state   <= SYNC;
            OE      <= 1'b1;
            bitOut  <= SYNC_PATTERN[0];
            onesCnt <= bumpOnes(onesCnt, SYNC_PATTERN[0]);
            bitIdx  <= 3'd1;
          end
        end
        SYNC: begin
          bitOut  <= SYNC_PATTERN[bitIdx];
          onesCnt <= bumpOnes(onesCnt, SYNC_PATTERN[bitIdx]);
          bitIdx  <= bitIdx + 3'd1;
          if (bitIdx == 3'd7) begin
            needByte <= 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          if (stuffDue) begin
            // Stuff bit: shift register and index hold.
            bitOut  <= 1'b0;
            onesCnt <= '0;
            if (lastPending) begin
              lastPending <= 1'b0;
              eopCnt      <= '0;
              state       <= EOP;
            end
          end else if (needByte) begin
            if (txValid) begin
              shiftReg <= txData;
              bitOut   <= txData[0];
              onesCnt  <= bumpOnes(onesCnt, txData[0]);
              isLast   <= txLast;
              needByte <= 1'b0;
              bitIdx   <= 3'd1;
            end else begin
              // Starved mid-packet: abort straight into EOP, this strobe counts as its first bit.
              underrun <= 1'b1;
              callEop  <= 1'b1;
              bitOut   <= 1'b0;
              needByte <= 1'b0;
              eopCnt   <= EOP_W'(1);
              state    <= EOP;
            end
          end else begin
            bitOut  <= curBit;
            onesCnt <= onesNext;
            bitIdx  <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) begin
              if (!isLast) begin
                needByte <= 1'b1;
              end else if (onesNext == ONES_MAX) begin
                lastPending <= 1'b1;
              end else begin
                eopCnt <= '0;
                state  <= EOP;
              end
            end
          end
        end
        EOP: begin
          if (eopCnt < EOP_MAX) begin
            callEop <= 1'b1;
            bitOut  <= 1'b0;
            eopCnt  <= eopCnt + EOP_W'(1);
          end else begin
            OE      <= 1'b0;
            callEop <= 1'b0;
            onesCnt <= '0;
            bitIdx  <= '0;
            eopCnt  <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Transmit-side stage directly upstream of the NRZI line encoder.
- Accepts packet bytes (PID plus payload) over a valid/ready handshake and prepends the SYNC byte.
- Shifts each byte out LSB-first, one bit per bit-time strobe, inserting USB stuff bits.
- Ends each packet with EOP signalling, providing the bit value, output-enable and EOP-request inputs the NRZI encoder consumes.

Parameters:
- SYNC_PATTERN, 8'h80, SYNC byte sent LSB-first before the first payload byte.
- STUFF_LIMIT, 6, consecutive emitted 1s after which one 0 is inserted.
- EOP_BITS, 3, bit-times callEop is held high (2 x SE0 + 1 x J at the encoder).

Ports:
- useClk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- checkData  in  1  one-cycle bit-time strobe; state and outputs advance only on cycles where it is high.
- txValid  in  1  txData holds a valid byte.
- txData  in  8  packet byte, PID first.
- txLast  in  1  qualifies txData as the final byte of the packet.
- txReady  out  1  byte accepted this cycle (combinational, see below).
- bitOut  out  1  unencoded stuffed bit for the NRZI stage.
- OE  out  1  transmit enable for the NRZI stage.
- callEop  out  1  EOP request to the NRZI stage.
- underrun  out  1  one-cycle pulse: a byte was needed but txValid was low.

Behaviour:
- Reset: synchronous, active-high. Clears state to IDLE, bitOut=0, OE=0, callEop=0, underrun=0, ones counter=0, bit index=0, needByte=0. Takes effect mid-packet; no EOP is emitted.
- All outputs except txReady are registered and change only on checkData cycles (underrun is the exception: it clears on the next clock). Outputs are stable between strobes.
- FSM states: IDLE, SYNC, DATA, EOP.
- IDLE:
  - OE=0, callEop=0.
  - On a strobe with txValid=1: go to SYNC, OE<=1, bitOut<=SYNC_PATTERN[0], bit index<=1.
  - txValid is not consumed here.
- SYNC: each strobe emits SYNC_PATTERN[idx]. After bit 7 is emitted, needByte<=1 and the state goes to DATA.
- DATA: each strobe emits in this priority:
  1. If ones counter == STUFF_LIMIT: emit 0, clear the counter, hold the shift register and index. txReady stays low.
  2. Else if needByte:
     - txReady = checkData & txValid.
     - On acceptance: load txData, emit txData[0], latch txLast, clear needByte.
     - If txValid=0: pulse underrun and go to EOP, with callEop<=1 on the same strobe.
  3. Else: emit the next shift-register bit.
     - After bit 7 of a non-last byte: needByte<=1.
     - After bit 7 of the last byte: go to EOP, unless a stuff bit is pending, in which case emit the stuff bit first, then go to EOP.
- Ones counter: increments on each emitted 1 (SYNC bits included), clears on each emitted 0, including stuff bits. Width is enough for STUFF_LIMIT.
- EOP:
  - callEop=1 and OE=1 for exactly EOP_BITS strobes, with bitOut=0.
  - On the next strobe: OE<=0, callEop<=0, counter cleared, go to IDLE.
  - A new packet may start on the strobe after that.
- txReady is never high outside DATA with needByte=1. Bytes offered in IDLE/SYNC/EOP are held, not dropped.
- Back-to-back packets: a txValid already high when IDLE is re-entered starts the next packet on the following strobe.

Test Plan:
- Single ACK: byte 0xD2 with txLast=1.
  - bitOut over strobes: 0,0,0,0,0,0,0,1 then 0,1,0,0,1,0,1,1.
  - Then callEop=1 for 3 strobes, then OE=0.
  - txReady pulses exactly once, on strobe 9.
- Stuffing: bytes 0xFF, 0xFF(last). After the SYNC bits: 1,1,1,1,1,0s,1,1,1, 1,1,1,0s,1,1,1,1,1 (s = stuff bit), 18 bits total, then EOP.
- Trailing stuff: 0xFC(last) gives 0,0,1,1,1,1,1,1 after SYNC, then a stuff 0, then callEop.
- Underrun: 0xC3 without txLast and txValid dropped afterwards → underrun pulses on strobe 17, callEop rises the same strobe, OE falls 3 strobes later.
- Strobe gaps: checkData every 4th clock → outputs stay constant between strobes; the sequence is identical to the first test.
- Reset asserted mid-DATA → the next clock shows OE=0, callEop=0, state IDLE. A fresh 0xD2 packet afterwards matches the first test.
